hsv_sweep_ctrl: RTL
===================

Name: hsv_sweep_ctrl

Overview:
CFU-side sequencer for the combinational HSV-to-RGB converter core. The CPU programs a start colour (16-bit hue, 8-bit saturation, 8-bit value), a hue step and a pixel count. The block then issues one conversion per cycle, with hue advancing by the step, and buffers the packed RGB results in a FIFO that the CPU drains with POP commands. It sits directly behind the CFU command/response bus and replaces the trivial combinational handshake with a registered, single-outstanding-command protocol.

Parameters:
DEPTH, 16, result FIFO entries; power of two, 2..256.
CNT_W, 16, width of the pixel-count register and counters.

Ports:
clk  in  1  system clock.
reset  in  1  asynchronous, active-high reset.
cmd_valid  in  1  command valid.
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
cmd_payload_function_id  in  10  [2:0] opcode; [9:3] ignored.
cmd_payload_inputs_0  in  32  operand 0.
cmd_payload_inputs_1  in  32  operand 1.
rsp_valid  out  1  response valid, held until rsp_ready.
rsp_ready  in  1  response consumed.
rsp_payload_response_ok  out  1  constant 1.
rsp_payload_outputs_0  out  32  response data.

Behaviour:
- Reset values: rsp_valid=0, rsp_payload_outputs_0=0, cmd_ready=1, state=IDLE, FIFO empty, remaining=0, hue/s/v/step=0.
- One command outstanding at a time. cmd_ready = !rsp_valid && !pop_stall. An accepted command produces rsp_valid on the next cycle. rsp_valid and outputs hold until rsp_ready.
- Opcodes:
  - 0 CONFIG: in0 = {h[31:16], s[15:8], v[7:0]}; in1 = {count[CNT_W+15:16], step[15:0]}. Accepted only in IDLE or DONE; loads registers, flushes the FIFO, moves to IDLE; response 0. In GEN it is ignored and the response is 0xFFFF_FFFF.
  - 1 START: if count==0, response 0 and state goes to DONE. Otherwise state goes to GEN; response 0.
  - 2 POP: if the FIFO is non-empty, response is the head word and the FIFO is popped. If the FIFO is empty and state==GEN, pop_stall holds cmd_ready low until an entry exists. If the FIFO is empty and state!=GEN, response 0.
  - 3 STATUS: response {state[31:30], fifo_full[29], fifo_empty[28], occupancy[27:20], remaining[CNT_W-1:0] zero-extended to [19:0]}.
  - 4..7: response 0, no side effects.
- State encoding: IDLE=0, GEN=1, DONE=2.
- FSM:
  - IDLE -> GEN on START with count>0.
  - GEN: each cycle with !fifo_full, the converter output for (hue,s,v) is pushed, hue <= hue+step (mod 2^16, wraps silently) and remaining decrements. When fifo_full, the cycle stalls with no push and no state change.
  - GEN -> DONE on the cycle remaining reaches 0 (after the final push).
  - DONE -> IDLE on CONFIG.
- Converter core is purely combinational; push data equals its output in the same cycle (latency command->first push = 1 cycle after START acceptance).
- Simultaneous push and pop in the same cycle: both occur; occupancy unchanged. Pop of the last entry while a push occurs returns the old head.
- Reset asserted mid-GEN: everything returns to reset values immediately. Buffered results are lost.
- Occupancy saturates at DEPTH; never overflows (push gated by full).

Optional Feature:
HSV_SWEEP_PERF_EN
- Defined: adds a 32-bit stall counter, incremented every GEN cycle blocked by fifo_full. Opcode 4 returns the counter value and clears it. CONFIG also clears it.
- Undefined: no counter; opcode 4 behaves as a reserved opcode (response 0).

Decomposition:
- Package hsv_sweep_pkg holds opcode constants (OP_CONFIG..OP_PERF), the state enum/encoding, and the STATUS field bit positions.
- One natural sub-module, hsv_sweep_fifo: synchronous FIFO of DEPTH x 32 with push, pop, flush, full, empty and occupancy outputs.
- The existing converter core is instantiated unchanged.

Test Plan:
1. CONFIG h=0,s=255,v=255, step=0x2000, count=4; START; POP x4 -> four words equal to converter outputs for hue 0x0000, 0x2000, 0x4000, 0x6000; STATUS then shows state=DONE, empty=1, remaining=0.
2. count=DEPTH+4, no POP for 40 cycles -> full=1, occupancy=16, remaining=4, state GEN. Then POP x20 -> all in hue order, ending in DONE; with PERF_EN, opcode 4 returns >=20 then 0.
3. h=0xF000, step=0x2000, count=2 -> second result corresponds to hue 0x1000 (wrap).
4. POP issued in GEN with empty FIFO (step: hold rsp_ready high, START then immediate POP) -> cmd_ready low until first push, response = first result; POP in IDLE with empty FIFO -> response 0 after 1 cycle.
5. CONFIG during GEN -> response 0xFFFF_FFFF, sweep unaffected. rsp_ready held low 5 cycles -> rsp_valid and data stable, cmd_ready low.
6. Assert reset mid-GEN with 7 entries buffered -> next-cycle STATUS returns state IDLE, empty, remaining 0; rsp_valid=0 during reset.

Source files
------------

// File: rtl/hsv_sweep_pkg.sv
// hsv_sweep_pkg: opcodes, FSM encoding and STATUS layout
// for the HSV sweep sequencer (hsv_sweep_ctrl).
package hsv_sweep_pkg;

  localparam logic [2:0] OP_CONFIG = 3'd0;
  localparam logic [2:0] OP_START  = 3'd1;
  localparam logic [2:0] OP_POP    = 3'd2;
  localparam logic [2:0] OP_STATUS = 3'd3;
  localparam logic [2:0] OP_PERF   = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GEN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int STS_STATE_LSB = 30;
  localparam int STS_FULL_BIT  = 29;
  localparam int STS_EMPTY_BIT = 28;
  localparam int STS_OCC_LSB   = 20;

  function automatic logic [31:0] pack_status(
    input state_t      st,
    input logic        full,
    input logic        empty,
    input logic [7:0]  occ,
    input logic [19:0] rem
  );
    logic [31:0] w;
    w = '0;
    w[STS_STATE_LSB +: 2] = st;
    w[STS_FULL_BIT]       = full;
    w[STS_EMPTY_BIT]      = empty;
    w[STS_OCC_LSB +: 8]   = occ;
    w[19:0]               = rem;
    return w;
  endfunction

endpackage

// File: rtl/hsv2rgb.sv
// hsv2rgb: combinational HSV to RGB converter core.
// Ports: hue[15:0], sat[7:0], val[7:0] in; rgb[23:0] = {r,g,b} out.
module hsv2rgb (
  input  logic [15:0] hue,
  input  logic [7:0]  sat,
  input  logic [7:0]  val,
  output logic [23:0] rgb
);

  function automatic logic [7:0] scale(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [15:0] m;
    m = 16'(a) * 16'(b);
    return m[15:8];
  endfunction

  // hue*6 splits the circle into six sectors;
  // bits [15:8] are the position inside the sector
  logic [18:0] h6;
  logic [2:0]  sector;
  logic [7:0]  f;
  logic [7:0]  p, q, t, sf, sfn;
  logic [7:0]  unused_frac;

  assign h6          = 19'(hue) * 19'd6;
  assign sector      = h6[18:16];
  assign f           = h6[15:8];
  assign unused_frac = h6[7:0];

  always_comb begin
    sf  = scale(sat, f);
    sfn = scale(sat, 8'hFF - f);
    p   = scale(val, 8'hFF - sat);
    q   = scale(val, 8'hFF - sf);
    t   = scale(val, 8'hFF - sfn);
    rgb = {val, p, q};
    unique case (sector)
      3'd0:    rgb = {val, t, p};
      3'd1:    rgb = {q, val, p};
      3'd2:    rgb = {p, val, t};
      3'd3:    rgb = {p, q, val};
      3'd4:    rgb = {t, p, val};
      default: rgb = {val, p, q};
    endcase
  end

endmodule

// File: rtl/hsv_sweep_fifo.sv
// hsv_sweep_fifo: DEPTH x W synchronous FIFO with flush.
// Ports: push/push_data, pop/pop_data (head), flush, full, empty, occupancy.
module hsv_sweep_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [W-1:0]               pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign full      = (cnt == (AW+1)'(DEPTH));
  assign empty     = (cnt == '0);
  assign occupancy = cnt;
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign pop_data  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/hsv_sweep_ctrl.sv
// hsv_sweep_ctrl: CFU sequencer sweeping hue through hsv2rgb into a FIFO.
// Ports: CFU cmd (valid/ready, function_id, inputs_0/1), rsp (valid/ready,
// response_ok, outputs_0). Optional HSV_SWEEP_PERF_EN adds a stall counter.
module hsv_sweep_ctrl
  import hsv_sweep_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [9:0]  cmd_payload_function_id,
  input  logic [31:0] cmd_payload_inputs_0,
  input  logic [31:0] cmd_payload_inputs_1,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_payload_response_ok,
  output logic [31:0] rsp_payload_outputs_0
);

  localparam int OCC_W = $clog2(DEPTH) + 1;

  state_t             state;
  logic [15:0]        hue;
  logic [15:0]        step;
  logic [7:0]         sat;
  logic [7:0]         val;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   remaining;

  logic [2:0]         op;
  logic               accept;
  logic               pop_stall;
  logic               gen_push;
  logic               fifo_pop;
  logic               cfg_ok;
  logic [23:0]        conv_rgb;
  logic [31:0]        fifo_head;
  logic               fifo_full;
  logic               fifo_empty;
  logic [OCC_W-1:0]   fifo_occ;
  logic [8:0]         occ9;
  logic [7:0]         occ8;
  logic [31:0]        rsp_next;
  logic               unused_bits;

  assign op          = cmd_payload_function_id[2:0];
  assign unused_bits = ^{cmd_payload_function_id[9:3],
                         cmd_payload_inputs_1};

  // A POP that would find nothing while the sweep is
  // still producing waits in the command slot instead
  assign pop_stall = cmd_valid && (op == OP_POP) &&
                     fifo_empty && (state == ST_GEN);
  assign cmd_ready = !rsp_valid && !pop_stall;
  assign accept    = cmd_valid && cmd_ready;

  assign gen_push  = (state == ST_GEN) && !fifo_full;
  assign fifo_pop  = accept && (op == OP_POP) && !fifo_empty;
  assign cfg_ok    = accept && (op == OP_CONFIG) &&
                     (state != ST_GEN);

  assign rsp_payload_response_ok = 1'b1;

  hsv2rgb u_conv (
    .hue (hue),
    .sat (sat),
    .val (val),
    .rgb (conv_rgb)
  );

  hsv_sweep_fifo #(
    .DEPTH (DEPTH),
    .W     (32)
  ) u_fifo (
    .clk       (clk),
    .rst       (reset),
    .push      (gen_push),
    .push_data ({8'h00, conv_rgb}),
    .pop       (fifo_pop),
    .flush     (cfg_ok),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .occupancy (fifo_occ)
  );

  // STATUS has 8 bits of occupancy; clamp for DEPTH=256
  assign occ9 = 9'(fifo_occ);
  assign occ8 = occ9[8] ? 8'hFF : occ9[7:0];

`ifdef HSV_SWEEP_PERF_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (cfg_ok) begin
      stall_cnt <= '0;
    end else if (accept && (op == OP_PERF)) begin
      stall_cnt <= '0;
    end else if ((state == ST_GEN) && fifo_full) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

  always_comb begin
    rsp_next = '0;
    unique case (op)
      OP_CONFIG:
        rsp_next = (state == ST_GEN) ? 32'hFFFF_FFFF : 32'h0;
      OP_POP:
        rsp_next = fifo_empty ? 32'h0 : fifo_head;
      OP_STATUS:
        rsp_next = pack_status(state, fifo_full, fifo_empty,
                               occ8, 20'(remaining));
`ifdef HSV_SWEEP_PERF_EN
      OP_PERF:
        rsp_next = stall_cnt;
`endif
      default:
        rsp_next = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid             <= 1'b0;
      rsp_payload_outputs_0 <= '0;
    end else if (accept) begin
      rsp_valid             <= 1'b1;
      rsp_payload_outputs_0 <= rsp_next;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid             <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      hue       <= '0;
      step      <= '0;
      sat       <= '0;
      val       <= '0;
      count     <= '0;
      remaining <= '0;
    end else if (cfg_ok) begin
      hue       <= cmd_payload_inputs_0[31:16];
      sat       <= cmd_payload_inputs_0[15:8];
      val       <= cmd_payload_inputs_0[7:0];
      step      <= cmd_payload_inputs_1[15:0];
      count     <= cmd_payload_inputs_1[CNT_W+15:16];
      remaining <= '0;
      state     <= ST_IDLE;
    end else if (accept && (op == OP_START) &&
                 (state != ST_GEN)) begin
      if (count == '0) begin
        state <= ST_DONE;
      end else begin
        state     <= ST_GEN;
        remaining <= count;
      end
    end else if (gen_push) begin
      hue       <= hue + step;
      remaining <= remaining - CNT_W'(1);
      if (remaining == CNT_W'(1)) state <= ST_DONE;
    end
  end

endmodule
